// File: rtl/seq_accum_alu.sv
// rtl/seq_accum_alu.sv - accumulator ALU with iterative shift and shift-add multiply
module seq_accum_alu #(
    parameter int W  = 4,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    output logic [2*W-1:0] acc,
    output logic           done,
    output logic           carry,
    output logic           zero
);

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_LOGIC  = 3'b010;
    localparam logic [2:0] OP_ORRED  = 3'b011;
    localparam logic [2:0] OP_ANDRED = 3'b100;
    localparam logic [2:0] OP_SHL    = 3'b101;
    localparam logic [2:0] OP_SHR    = 3'b110;
    localparam logic [2:0] OP_MUL    = 3'b111;

    // Wide enough to compare a against 2W without truncating either side.
    localparam int AW = ((W > CW) ? W : CW) + 1;
    localparam logic [AW-1:0] L_TWO_W = AW'(2 * W);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [2*W-1:0]  r_acc;
    logic            r_carry;
    logic            r_zero;
    logic [2:0]      r_op;
    logic [CW-1:0]   r_cnt;
    logic [2*W-1:0]  r_work;
    logic [2*W-1:0]  r_mcand;
    logic [W-1:0]    r_mplier;

    logic [W-1:0]    w_b;
    logic            w_accept;
    logic            w_multi;
    logic [W:0]      w_sum;
    logic [W:0]      w_diff;
    logic [2*W-1:0]  w_res;
    logic            w_res_carry;
    logic [AW-1:0]   w_a_ext;
    logic [CW-1:0]   w_shift_n;
    logic [2*W-1:0]  w_step_work;
    logic            w_last_step;

    assign w_b         = r_acc[W-1:0];
    assign w_accept    = in_valid & in_ready;
    assign w_sum       = {1'b0, a} + {1'b0, w_b};
    assign w_diff      = {1'b0, a} - {1'b0, w_b};
    assign w_a_ext     = AW'(a);
    assign w_shift_n   = (w_a_ext >= L_TWO_W) ? CW'(2 * W) : CW'(w_a_ext);
    assign w_last_step = (r_cnt == CW'(1));
    // A shift by zero has nothing to iterate, so it completes like a single-cycle op.
    assign w_multi     = (op == OP_MUL) || (((op == OP_SHL) || (op == OP_SHR)) && (a != '0));

    assign acc   = r_acc;
    assign carry = r_carry;
    assign zero  = r_zero;

    // Single-cycle result and carry, computed from a and the current accumulator.
    always_comb begin
        w_res       = '0;
        w_res_carry = 1'b0;
        case (op)
            OP_ADD: begin
                w_res       = {{(W-1){1'b0}}, w_sum};
                w_res_carry = w_sum[W];
            end
            OP_SUB: begin
                w_res       = {{W{1'b0}}, w_diff[W-1:0]};
                w_res_carry = w_diff[W];
            end
            OP_LOGIC:  w_res = {a | w_b, a ^ w_b};
            OP_ORRED:  w_res = {{(2*W-1){1'b0}}, |{a, w_b}};
            OP_ANDRED: w_res = {{(2*W-1){1'b0}}, &{a, w_b}};
            default:   w_res = {{W{1'b0}}, w_b};
        endcase
    end

    // One iteration of the latched multi-cycle op on the working register.
    always_comb begin
        w_step_work = r_work;
        case (r_op)
            OP_SHL:  w_step_work = r_work << 1;
            OP_SHR:  w_step_work = r_work >> 1;
            OP_MUL:  w_step_work = r_mplier[0] ? (r_work + r_mcand) : r_work;
            default: w_step_work = r_work;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake outputs; DONE accepts just like IDLE.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_BUSY: begin
                in_ready = 1'b0;
                if (w_last_step) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = w_accept ? (w_multi ? S_BUSY : S_DONE) : S_IDLE;
            end
            default: begin
                w_next_state = w_accept ? (w_multi ? S_BUSY : S_DONE) : S_IDLE;
            end
        endcase
    end

    // Accumulator, flags and working registers; acc only changes on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_op     <= OP_ADD;
            r_cnt    <= '0;
            r_work   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (w_accept) begin
            if (w_multi) begin
                r_op     <= op;
                r_mplier <= a;
                r_mcand  <= {{W{1'b0}}, w_b};
                if (op == OP_MUL) begin
                    r_work <= '0;
                    r_cnt  <= CW'(W);
                end else begin
                    r_work <= {{W{1'b0}}, w_b};
                    r_cnt  <= w_shift_n;
                end
            end else begin
                r_acc   <= w_res;
                r_carry <= w_res_carry;
                r_zero  <= (w_res == '0);
            end
        end else if (r_state == S_BUSY) begin
            r_work   <= w_step_work;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (w_last_step) begin
                r_acc   <= w_step_work;
                r_carry <= 1'b0;
                r_zero  <= (w_step_work == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_accum_alu.sv
// tb/tb_seq_accum_alu.sv - self-checking bench for seq_accum_alu
module tb_seq_accum_alu;

    localparam int W  = 4;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [2*W-1:0] acc;
    logic           done;
    logic           carry;
    logic           zero;

    int n_checks = 0;
    int n_fail   = 0;
    int m_acc    = 0;

    always #5 clk = ~clk;

    seq_accum_alu #(.W(W), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .acc      (acc),
        .done     (done),
        .carry    (carry),
        .zero     (zero)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: result, carry and busy-cycle count straight from the opcode rules.
    function automatic void ref_op(input int o, input int av, input int accv,
                                   output int res, output int cy, output int n);
        int m, b;
        m   = (1 << W) - 1;
        b   = accv & m;
        cy  = 0;
        n   = 0;
        res = 0;
        case (o)
            0: begin res = av + b; cy = (res > m) ? 1 : 0; end
            1: begin res = (av - b) & m; cy = (av < b) ? 1 : 0; end
            2: res = ((av | b) << W) | (av ^ b);
            3: res = ((av | b) != 0) ? 1 : 0;
            4: res = ((av == m) && (b == m)) ? 1 : 0;
            5: begin
                res = (b << av) & ((1 << (2 * W)) - 1);
                n   = (av > 2 * W) ? 2 * W : av;
            end
            6: begin
                res = b >> av;
                n   = (av > 2 * W) ? 2 * W : av;
            end
            default: begin res = av * b; n = W; end
        endcase
    endfunction

    // Issue one op from a negedge, follow it to its done cycle and check it.
    // Returns at the negedge of the done cycle so the next op can go back-to-back.
    task automatic run_op(input int o, input int av, input bit hold = 1'b0,
                          input int ho = 0, input int ha = 0);
        int res, cy, n, waited;
        op       = o[2:0];
        a        = av[W-1:0];
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("ready_wait", in_ready, 1);
        ref_op(o, av, m_acc, res, cy, n);
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            op = ho[2:0];
            a  = ha[W-1:0];
        end else begin
            in_valid = 1'b0;
        end
        for (int c = 0; c < n; c++) begin
            check_eq("busy_ready", in_ready, 0);
            check_eq("busy_done", done, 0);
            check_eq("busy_acc_hold", acc, m_acc);
            @(negedge clk);
        end
        check_eq("done_pulse", done, 1);
        check_eq("done_ready", in_ready, 1);
        check_eq("acc", acc, res);
        check_eq("carry", carry, cy);
        check_eq("zero", zero, (res == 0) ? 1 : 0);
        m_acc = res;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;
        reset    = 1'b1;
        in_valid = 1'b0;
        op       = '0;
        a        = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_acc", acc, 0);
        check_eq("rst_carry", carry, 0);
        check_eq("rst_zero", zero, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ready", in_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // Directed sequence from the plan
        run_op(0, 3);
        run_op(0, 15);
        run_op(7, 7);
        run_op(5, 3);
        run_op(6, 9);
        run_op(5, 0);
        run_op(0, 6);
        run_op(2, 10);
        run_op(1, 12);
        run_op(1, 0);
        run_op(0, 5);
        run_op(1, 2);

        // Reset in the second busy cycle of a multiply aborts it
        op       = 3'b111;
        a        = 4'd5;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("abort_busy", in_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_acc", acc, 0);
        check_eq("abort_ready", in_ready, 1);
        check_eq("abort_done", done, 0);
        seen_done = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        check_eq("abort_no_done", seen_done, 0);
        m_acc = 0;

        // A held ADD is only taken in the multiply's done cycle
        run_op(0, 3);
        run_op(7, 7, 1'b1, 0, 9);
        run_op(0, 9);

        // Randomised ops, sometimes back-to-back, sometimes with idle gaps
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, (1 << W) - 1)));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
